// File: rtl/count_sampler.sv
// Samples a free-running counter into a small FIFO, tagging each entry with a
// wrap flag that records any counter wrap seen since the previous accepted capture.
module count_sampler #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_value,
  input  logic                       sample_en,
  output logic [WIDTH:0]             out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [3:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] prev_value_q, prev_value_d;
  logic             prev_ok_q, prev_ok_d;
  logic             wrap_pending_q, wrap_pending_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic [3:0]       drop_count_q, drop_count_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];

  logic wrap_now_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign out_valid  = (level_q != '0);
  assign full       = (level_q == LVL_FULL);
  assign level      = level_q;
  assign drop_count = drop_count_q;
  assign out_data   = mem_q[rptr_q];

  // Wrap detection and push/pop/drop decisions plus next-state for all flops.
  always_comb begin
    prev_value_d   = in_value;
    prev_ok_d      = 1'b1;
    wrap_pending_d = wrap_pending_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    level_d        = level_q;
    drop_count_d   = drop_count_q;
    mem_d          = mem_q;

    wrap_now_s = prev_ok_q && (in_value < prev_value_q);
    pop_s      = out_valid && out_ready;
    push_s     = sample_en && (!full || pop_s);
    drop_s     = sample_en && full && !pop_s;

    // A full FIFO popping this cycle writes into the slot being vacated.
    if (push_s) begin
      mem_d[wptr_q]  = {wrap_pending_q | wrap_now_s, in_value};
      wptr_d         = wptr_q + PTR_ONE;
      wrap_pending_d = 1'b0;
    end else if (wrap_now_s) begin
      wrap_pending_d = 1'b1;
    end else begin
      wrap_pending_d = wrap_pending_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end

    if (drop_s && (drop_count_q != 4'd15)) begin
      drop_count_d = drop_count_q + 4'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // State registers; reset also clears the storage so out_data reads zero.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_value_q   <= '0;
      prev_ok_q      <= 1'b0;
      wrap_pending_q <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      level_q        <= '0;
      drop_count_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      prev_value_q   <= prev_value_d;
      prev_ok_q      <= prev_ok_d;
      wrap_pending_q <= wrap_pending_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      level_q        <= level_d;
      drop_count_q   <= drop_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler (WIDTH=7, DEPTH=4) with hand-computed expectations.
module tb_count_sampler;

  logic       clock;
  logic       rst_n;
  logic [6:0] in_value;
  logic       sample_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic [2:0] level;
  logic [3:0] drop_count;

  int n_total;
  int n_bad;

  count_sampler #(.WIDTH(7), .DEPTH(4)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_value   (in_value),
    .sample_en  (sample_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .level      (level),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample just after the edge.
  task automatic cyc(input logic [6:0] v, input logic sen, input logic rdy);
    in_value  = v;
    sample_en = sen;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_value  = 7'd0;
    sample_en = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // single capture, one-cycle latency
    cyc(7'd5, 1'b1, 1'b0);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_data", 32'(out_data), 32'h05);
    chk("one_level", 32'(level), 32'd1);
    cyc(7'd6, 1'b0, 1'b1);
    chk("one_pop_level", 32'(level), 32'd0);

    // wrap flag on capture at the wrap cycle
    cyc(7'd126, 1'b0, 1'b0);
    cyc(7'd127, 1'b0, 1'b0);
    cyc(7'd0, 1'b1, 1'b0);
    chk("wrap_data", 32'(out_data), 32'h80);
    chk("wrap_level", 32'(level), 32'd1);
    cyc(7'd1, 1'b0, 1'b0);
    cyc(7'd2, 1'b0, 1'b0);
    cyc(7'd3, 1'b1, 1'b0);
    chk("wrap_level2", 32'(level), 32'd2);
    cyc(7'd4, 1'b0, 1'b1);
    chk("after_wrap_data", 32'(out_data), 32'h03);
    cyc(7'd5, 1'b0, 1'b1);
    chk("drain_level", 32'(level), 32'd0);
    cyc(7'd6, 1'b0, 1'b1);
    chk("empty_ready_level", 32'(level), 32'd0);
    chk("empty_ready_valid", 32'(out_valid), 32'd0);

    // fill past capacity
    for (int i = 7; i <= 12; i++) cyc(7'(i), 1'b1, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_drop", 32'(drop_count), 32'd2);
    chk("fill_head", 32'(out_data), 32'h07);
    cyc(7'd13, 1'b0, 1'b0);
    chk("hold_head", 32'(out_data), 32'h07);

    // push and pop together while full
    cyc(7'd14, 1'b1, 1'b1);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_drop", 32'(drop_count), 32'd2);
    chk("pp_head", 32'(out_data), 32'h08);

    // 20 drops while full, with a wrap (127 -> 0) in the middle
    for (int i = 0; i < 20; i++) cyc(7'((118 + i) % 128), 1'b1, 1'b0);
    chk("sat_drop", 32'(drop_count), 32'd15);
    chk("sat_level", 32'(level), 32'd4);
    cyc(7'd10, 1'b0, 1'b1);
    chk("drain_a", 32'(out_data), 32'h09);
    cyc(7'd11, 1'b0, 1'b1);
    chk("drain_b", 32'(out_data), 32'h0A);
    cyc(7'd12, 1'b0, 1'b1);
    chk("tail_value", 32'(out_data), 32'h0E);
    cyc(7'd13, 1'b0, 1'b1);
    chk("drained", 32'(level), 32'd0);
    cyc(7'd14, 1'b1, 1'b0);
    chk("kept_wrap", 32'(out_data), 32'h8E);
    cyc(7'd15, 1'b1, 1'b0);
    cyc(7'd16, 1'b0, 1'b1);
    chk("wrap_cleared", 32'(out_data), 32'h0F);
    chk("drop_held", 32'(drop_count), 32'd15);

    // asynchronous reset mid-operation with a pending wrap
    cyc(7'd17, 1'b1, 1'b0);
    cyc(7'd18, 1'b1, 1'b0);
    cyc(7'd5, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    cyc(7'd6, 1'b1, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h06);
    chk("post_rst_level", 32'(level), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/count_sampler.md
COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 7, bit width of the sampled counter value.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_value  input  WIDTH  upstream free-running counter value, +1 per cycle, wraps 2^WIDTH-1 -> 0.
REQ-006 SHALL have port sample_en  input  1  capture request for in_value this cycle.
REQ-007 SHALL have port out_data  output  WIDTH+1  head entry: bit WIDTH = wrap flag, low bits = captured value.
REQ-008 SHALL have port out_valid  output  1  FIFO not empty.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port full  output  1  level == DEPTH.
REQ-011 SHALL have port level  output  log2(DEPTH)+1  occupied entries.
REQ-012 SHALL have port drop_count  output  4  saturating count of rejected captures.

Function
REQ-013 SHALL register in_value each cycle into prev_value, and set prev_ok one cycle after reset release.
REQ-014 SHALL detect wrap_now = prev_ok && (in_value < prev_value), unsigned WIDTH-bit compare.
REQ-015 SHALL set sticky wrap_pending on wrap_now when no push occurs that cycle.
REQ-016 SHALL push {wrap_pending | wrap_now, in_value} when sample_en && (!full || pop); pop = out_valid && out_ready.
REQ-017 SHALL clear wrap_pending on any accepted push, including wrap_now that same cycle.
REQ-018 SHALL, on sample_en && full && !pop, drop the sample, keep wrap_pending, and increment drop_count, saturating at 15.
REQ-019 SHALL pop the head entry on pop and advance the read pointer modulo DEPTH.
REQ-020 SHALL advance the write pointer modulo DEPTH on push; pointers wrap without loss.
REQ-021 SHALL keep level unchanged on simultaneous push and pop, at any level including full.
REQ-022 SHALL not fall through: a push into an empty FIFO raises out_valid the next cycle (1-cycle latency).
REQ-023 SHALL hold out_data stable while out_valid && !out_ready.
REQ-024 SHALL ignore out_ready when empty; level never underflows.
REQ-025 SHALL drive out_data from registered storage; out_valid, full, level decoded from registered pointers/level only.

Reset
REQ-026 SHALL on rst_n low immediately clear read/write pointers, level, drop_count, wrap_pending, prev_ok, prev_value.
REQ-027 SHALL drive out_valid=0, full=0, level=0, drop_count=0 during reset; out_data = 0 (storage cleared).
REQ-028 SHALL discard all FIFO contents on reset mid-operation; no pop is reported for discarded entries.
REQ-029 SHALL not flag a wrap on the first valid cycle after reset release, whatever in_value is.

Verification
REQ-030 SHALL verify: reset, in_value=5, sample_en 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x05, level=1.
REQ-031 SHALL verify: in_value 126,127,0 with sample_en only at 0 -> out_data=0x80 (wrap=1, value 0); next capture at 3 -> 0x03.
REQ-032 SHALL verify: out_ready=0, 6 consecutive samples, DEPTH=4 -> full=1, level=4, drop_count=2, head = first sample.
REQ-033 SHALL verify: full FIFO, sample_en && out_ready same cycle -> level stays 4, drop_count unchanged, new value at tail.
REQ-034 SHALL verify: 20 drops while full -> drop_count saturates at 15; wrap during drops is kept and marked on next accepted push.
REQ-035 SHALL verify: rst_n low with level=3 -> out_valid=0, level=0 asynchronously; first sample after release has wrap=0.
